// File: rtl/systolic_ws_array.sv
`default_nettype none
// ============================================================================
// Module   : systolic_ws_array
// Purpose  : Weight-stationary systolic MAC array with input skew, output
//            deskew and a load/stream/drain controller for safe weight reload.
// Revision : 1.0
// ============================================================================
module systolic_ws_array #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int ROWS       = 10,
    parameter int COLS       = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             w_valid,
    output logic                             w_ready,
    input  logic [COLS-1:0][DATA_WIDTH-1:0]  w_data,
    input  logic                             x_valid,
    output logic                             x_ready,
    input  logic [ROWS-1:0][DATA_WIDTH-1:0]  x_data,
    output logic                             y_valid,
    input  logic                             y_ready,
    output logic [COLS-1:0][ACC_WIDTH-1:0]   y_data,
    output logic [1:0]                       state_o
);
    localparam int LAT   = ROWS + COLS;
    localparam int CNT_W = $clog2(LAT + 1);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [ROW_W-1:0]             row_q, row_d;
    logic [CNT_W-1:0]             infl_q, infl_d;
    logic [LAT-1:0]               vld_q, vld_d;
    logic signed [DATA_WIDTH-1:0] wt_q [ROWS][COLS];
    logic signed [DATA_WIDTH-1:0] wt_d [ROWS][COLS];
    logic signed [DATA_WIDTH-1:0] xin  [ROWS][COLS];
    logic signed [ACC_WIDTH-1:0]  ps   [ROWS][COLS];
    logic                         adv, x_hs, w_hs, y_hs;

    assign adv     = y_ready || !y_valid;
    assign w_ready = (state_q == ST_LOAD);
    assign x_ready = (state_q == ST_STREAM) && adv;
    assign x_hs    = x_valid && x_ready;
    assign w_hs    = w_valid && w_ready;
    assign y_hs    = y_valid && y_ready;
    assign y_valid = vld_q[LAT-1];
    assign state_o = state_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        infl_d  = infl_q;
        wt_d    = wt_q;
        vld_d   = vld_q;
        if (adv) begin
            vld_d = {vld_q[LAT-2:0], x_hs};
        end
        case (state_q)
            ST_LOAD: begin
                if (w_hs) begin
                    for (int j = 0; j < COLS; j++) begin
                        wt_d[row_q][j] = w_data[j];
                    end
                    if (row_q == ROW_W'(ROWS - 1)) begin
                        row_d   = '0;
                        state_d = ST_STREAM;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            ST_STREAM: begin
                if (w_valid) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (infl_q == '0) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
        if (x_hs && !y_hs) begin
            infl_d = infl_q + CNT_W'(1);
        end else if (y_hs && !x_hs) begin
            infl_d = infl_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
            row_q   <= '0;
            infl_q  <= '0;
            vld_q   <= '0;
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    wt_q[i][j] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            infl_q  <= infl_d;
            vld_q   <= vld_d;
            wt_q    <= wt_d;
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        // Bubbles carry zero data so idle slots never produce stray sums.
        logic signed [DATA_WIDTH-1:0] row_in;
        assign row_in = x_hs ? x_data[i] : '0;

        if (i == 0) begin : g_noskew
            assign xin[i][0] = row_in;
        end else begin : g_skew
            logic signed [DATA_WIDTH-1:0] sk_d [i];
            logic signed [DATA_WIDTH-1:0] sk_q [i];
            always_comb begin
                sk_d[0] = row_in;
                for (int k = 1; k < i; k++) begin
                    sk_d[k] = sk_q[k-1];
                end
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < i; k++) begin
                        sk_q[k] <= '0;
                    end
                end else if (adv) begin
                    sk_q <= sk_d;
                end
            end
            assign xin[i][0] = sk_q[i-1];
        end

        for (genvar j = 0; j < COLS; j++) begin : g_col
            logic signed [ACC_WIDTH-1:0]    ps_in, ps_d, ps_q;
            logic signed [2*DATA_WIDTH-1:0] prod;

            if (i == 0) begin : g_top
                assign ps_in = '0;
            end else begin : g_acc
                assign ps_in = ps[i-1][j];
            end

            always_comb begin
                prod = xin[i][j] * wt_q[i][j];
                ps_d = ps_in + ACC_WIDTH'(prod);
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ps_q <= '0;
                end else if (adv) begin
                    ps_q <= ps_d;
                end
            end
            assign ps[i][j] = ps_q;

            if (j < COLS - 1) begin : g_xfwd
                logic signed [DATA_WIDTH-1:0] x_d, x_q;
                always_comb x_d = xin[i][j];
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        x_q <= '0;
                    end else if (adv) begin
                        x_q <= x_d;
                    end
                end
                assign xin[i][j+1] = x_q;
            end
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_dsk
        localparam int ND = COLS - 1 - j;
        logic [ACC_WIDTH-1:0] tail, y_d, y_q;

        if (ND == 0) begin : g_direct
            assign tail = ps[ROWS-1][j];
        end else begin : g_regs
            logic [ACC_WIDTH-1:0] ds_d [ND];
            logic [ACC_WIDTH-1:0] ds_q [ND];
            always_comb begin
                ds_d[0] = ps[ROWS-1][j];
                for (int k = 1; k < ND; k++) begin
                    ds_d[k] = ds_q[k-1];
                end
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < ND; k++) begin
                        ds_q[k] <= '0;
                    end
                end else if (adv) begin
                    ds_q <= ds_d;
                end
            end
            assign tail = ds_q[ND-1];
        end

        always_comb y_d = tail;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                y_q <= '0;
            end else if (adv) begin
                y_q <= y_d;
            end
        end
        assign y_data[j] = y_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_ws_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_ws_array
// Purpose  : Directed self-checking bench for systolic_ws_array.
// Revision : 1.0
// ============================================================================
module tb_systolic_ws_array;
    localparam int DW    = 16;
    localparam int AW    = 32;
    localparam int ROWS  = 10;
    localparam int COLS  = 5;

    typedef logic [COLS-1:0][AW-1:0] yvec_t;
    typedef logic [ROWS-1:0][DW-1:0] xvec_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     w_valid, w_ready;
    logic [COLS-1:0][DW-1:0]  w_data;
    logic                     x_valid, x_ready;
    xvec_t                    x_data;
    logic                     y_valid, y_ready;
    yvec_t                    y_data;
    logic [1:0]               state_o;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;
    yvec_t got[$];
    int    got_cyc[$];

    systolic_ws_array #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .rst(rst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
        .state_o(state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && y_valid && y_ready) begin
            got.push_back(y_data);
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] wval(input int mode, input int k, input int j);
        case (mode)
            0:       return (k == j) ? DW'(1) : DW'(0);
            1:       return DW'(1);
            2:       return DW'(j + 1);
            default: return DW'(-32768);
        endcase
    endfunction

    function automatic xvec_t xsplat(input int v);
        xvec_t r;
        for (int i = 0; i < ROWS; i++) r[i] = DW'(v);
        return r;
    endfunction

    function automatic xvec_t xramp();
        xvec_t r;
        for (int i = 0; i < ROWS; i++) r[i] = DW'(i + 1);
        return r;
    endfunction

    function automatic yvec_t ysplat(input logic [AW-1:0] v);
        yvec_t r;
        for (int j = 0; j < COLS; j++) r[j] = v;
        return r;
    endfunction

    // Keeps w_valid high until all ROWS beats have handshaken.
    task automatic load_w(input int mode);
        bit hs;
        int t;
        for (int k = 0; k < ROWS; k++) begin
            for (int j = 0; j < COLS; j++) w_data[j] = wval(mode, k, j);
            w_valid = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                hs = w_ready;
                tick();
                t++;
            end while (!hs && t < 200);
            if (!hs) check("load_timeout", hs, 1);
        end
        w_valid = 1'b0;
    endtask

    task automatic send_x(input xvec_t v);
        bit hs;
        int t;
        x_data  = v;
        x_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            hs = x_ready;
            tick();
            t++;
        end while (!hs && t < 500);
        x_valid = 1'b0;
        if (!hs) check("send_timeout", hs, 1);
    endtask

    task automatic wait_res(input int n);
        int t;
        t = 0;
        while (got.size() < n && t < 400) begin
            tick();
            t++;
        end
    endtask

    initial begin
        int    lat;
        yvec_t e;
        rst = 1'b1; w_valid = 1'b0; w_data = '0;
        x_valid = 1'b0; x_data = '0; y_ready = 1'b1;
        repeat (3) tick();
        check("rst_w_ready", w_ready, 1);
        check("rst_x_ready", x_ready, 0);
        check("rst_y_valid", y_valid, 0);
        check("rst_y_data", y_data, 0);
        check("rst_state", state_o, 0);
        rst = 1'b0;
        tick();

        // Identity weights: single vector, latency and values
        load_w(0);
        check("load_to_stream", state_o, 1);
        check("stream_x_ready", x_ready, 1);
        x_data = xramp(); x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        lat = 1;
        while (!y_valid && lat < 40) begin tick(); lat++; end
        check("latency", lat, 15);
        for (int j = 0; j < COLS; j++) e[j] = AW'(j + 1);
        check("identity_y", y_data, e);
        tick();

        // Reload to all-ones; empty pipeline means a one-cycle DRAIN
        for (int j = 0; j < COLS; j++) w_data[j] = wval(1, 0, j);
        w_valid = 1'b1;
        tick();
        check("drain_entry", state_o, 2);
        tick();
        check("drain_one_cycle", state_o, 0);
        load_w(1);

        // Back-to-back burst
        got.delete(); got_cyc.delete();
        for (int n = 1; n <= 20; n++) send_x(xsplat(n));
        wait_res(20);
        check("burst_count", got.size(), 20);
        for (int n = 0; n < 20 && n < got.size(); n++) check("burst_y", got[n], ysplat(AW'(10 * (n + 1))));
        if (got.size() == 20) check("burst_contig", got_cyc[19] - got_cyc[0], 19);

        // Burst with a 7-cycle downstream stall
        got.delete(); got_cyc.delete();
        fork
            begin
                for (int n = 1; n <= 20; n++) send_x(xsplat(n));
            end
            begin
                yvec_t held;
                int t;
                t = 0;
                while (got.size() < 3 && t < 200) begin @(posedge clk); #2; t++; end
                y_ready = 1'b0;
                held = '0;
                for (int k = 0; k < 7; k++) begin
                    @(negedge clk);
                    if (k == 0) held = y_data;
                    else check("stall_hold", y_data, held);
                    check("stall_y_valid", y_valid, 1);
                    check("stall_x_ready", x_ready, 0);
                end
                @(posedge clk); #2;
                y_ready = 1'b1;
            end
        join
        wait_res(20);
        check("stall_count", got.size(), 20);
        for (int n = 0; n < 20 && n < got.size(); n++) check("stall_y", got[n], ysplat(AW'(10 * (n + 1))));

        // Reload with three vectors in flight
        got.delete(); got_cyc.delete();
        for (int n = 2; n <= 4; n++) send_x(xsplat(n));
        for (int j = 0; j < COLS; j++) w_data[j] = wval(2, 0, j);
        w_valid = 1'b1;
        tick();
        check("reload_drain", state_o, 2);
        check("reload_x_ready", x_ready, 0);
        lat = 0;
        while (!w_ready && lat < 200) begin tick(); lat++; end
        check("reload_load", state_o, 0);
        check("reload_old_count", got.size(), 3);
        for (int n = 0; n < 3 && n < got.size(); n++) check("reload_old_y", got[n], ysplat(AW'(10 * (n + 2))));
        load_w(2);
        got.delete();
        send_x(xsplat(1));
        wait_res(1);
        for (int j = 0; j < COLS; j++) e[j] = AW'(10 * (j + 1));
        if (got.size() > 0) check("reload_new_y", got[0], e);
        else check("reload_new_count", got.size(), 1);

        // Signed wrap: 10 * (-32768)^2 mod 2^32
        load_w(3);
        got.delete();
        send_x(xsplat(-32768));
        wait_res(1);
        if (got.size() > 0) check("wrap_y", got[0], ysplat(32'h8000_0000));
        else check("wrap_count", got.size(), 1);

        // Asynchronous reset mid-burst
        x_data = xsplat(1); x_valid = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check("midrst_y_valid", y_valid, 0);
        check("midrst_x_ready", x_ready, 0);
        check("midrst_w_ready", w_ready, 1);
        check("midrst_state", state_o, 0);
        check("midrst_y_data", y_data, 0);
        x_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        load_w(1);
        got.delete();
        repeat (30) tick();
        check("no_stale", got.size(), 0);
        send_x(xramp());
        wait_res(1);
        if (got.size() > 0) check("post_rst_y", got[0], ysplat(AW'(55)));
        else check("post_rst_count", got.size(), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
